// File: rtl/arbitro_botoes.sv
// Round-robin arbiter for debounced button pulses: latches each press as a pending
// request, offers them one at a time over valid/ready and enforces a cooldown after each grant.
module arbitro_botoes #(
  parameter int N_BOTOES = 3,
  parameter int ID_W     = 2,
  parameter int COOLDOWN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] pulso_in,
  output logic                acao_valid,
  output logic [ID_W-1:0]     acao_id,
  input  logic                acao_ready,
  output logic                ocupado,
  output logic [N_BOTOES-1:0] pendentes,
  output logic [7:0]          descartes
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_COOLDOWN
  } state_t;

  localparam logic [15:0] CNT_LOAD = (COOLDOWN > 0) ? 16'(COOLDOWN - 1) : 16'd0;

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [15:0]       cnt_reg;

  logic                handshake;
  logic [N_BOTOES-1:0] clr_vec;
  logic [N_BOTOES-1:0] drop_vec;
  logic [N_BOTOES-1:0] pend_next;
  logic [3:0]          drop_cnt;
  logic [8:0]          desc_sum;
  logic [7:0]          desc_next;
  logic [ID_W-1:0]     pick;
  logic                found;
  int                  idx;

  // acao_valid is only ever high in OFFER, so it doubles as the state qualifier here
  assign handshake = acao_valid & acao_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_BOTOES; gi++) begin : g_bit
      assign clr_vec[gi]  = handshake && (acao_id == ID_W'(gi));
      assign drop_vec[gi] = pulso_in[gi] & pendentes[gi] & ~clr_vec[gi];
    end
  endgenerate

  // A new pulse wins over the clear on the same edge
  assign pend_next = (pendentes & ~clr_vec) | pulso_in;

  always_comb begin
    drop_cnt = 4'd0;
    for (int i = 0; i < N_BOTOES; i++) begin
      drop_cnt = drop_cnt + {3'd0, drop_vec[i]};
    end
  end

  assign desc_sum  = {1'b0, descartes} + {5'd0, drop_cnt};
  assign desc_next = desc_sum[8] ? 8'hFF : desc_sum[7:0];

  // First pending bit after the last grant, ascending with wrap
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_BOTOES; k++) begin
      idx = (int'(ptr_reg) + k) % N_BOTOES;
      if (!found && pendentes[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= ID_W'(N_BOTOES - 1);
      cnt_reg    <= 16'd0;
      pendentes  <= '0;
      descartes  <= 8'd0;
      acao_valid <= 1'b0;
      acao_id    <= '0;
      ocupado    <= 1'b0;
    end else begin
      pendentes <= pend_next;
      descartes <= desc_next;
      case (state_reg)
        ST_IDLE: begin
          if (|pendentes) begin
            acao_id    <= pick;
            acao_valid <= 1'b1;
            ocupado    <= 1'b1;
            state_reg  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (acao_ready) begin
            acao_valid <= 1'b0;
            ptr_reg    <= acao_id;
            if (COOLDOWN > 0) begin
              cnt_reg   <= CNT_LOAD;
              state_reg <= ST_COOLDOWN;
            end else begin
              ocupado   <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_COOLDOWN: begin
          if (cnt_reg == 16'd0) begin
            ocupado   <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        default: begin
          acao_valid <= 1'b0;
          ocupado    <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_botoes.sv
// Bench for arbitro_botoes: two instances (cooldown 4 and 0) share stimulus and are
// compared against an integer-level model of pending requests, grants and cooldown.
module tb_arbitro_botoes;

  logic       clk;
  logic       rst_n;
  logic [2:0] pulso_in;
  logic       acao_ready;

  logic       valid_a, valid_b;
  logic [1:0] id_a, id_b;
  logic       ocup_a, ocup_b;
  logic [2:0] pend_a, pend_b;
  logic [7:0] desc_a, desc_b;

  int checks   = 0;
  int failures = 0;

  arbitro_botoes #(.N_BOTOES(3), .ID_W(2), .COOLDOWN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulso_in(pulso_in),
    .acao_valid(valid_a), .acao_id(id_a), .acao_ready(acao_ready),
    .ocupado(ocup_a), .pendentes(pend_a), .descartes(desc_a)
  );

  arbitro_botoes #(.N_BOTOES(3), .ID_W(2), .COOLDOWN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulso_in(pulso_in),
    .acao_valid(valid_b), .acao_id(id_b), .acao_ready(acao_ready),
    .ocupado(ocup_b), .pendentes(pend_b), .descartes(desc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index 0 -> cooldown 4, index 1 -> cooldown 0
  int         cdv[2]     = '{4, 0};
  logic [2:0] m_pend[2]  = '{3'b000, 3'b000};
  int         m_desc[2]  = '{0, 0};
  int         m_last[2]  = '{2, 2};
  int         m_id[2]    = '{0, 0};
  int         m_cool[2]  = '{0, 0};
  bit         m_offer[2] = '{1'b0, 1'b0};

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_pend[m] = 3'b000; m_desc[m] = 0; m_last[m] = 2;
        m_id[m] = 0; m_cool[m] = 0; m_offer[m] = 1'b0;
      end else begin
        logic [2:0] np;
        bit hs;
        hs = m_offer[m] && acao_ready;
        np = m_pend[m];
        if (hs) np[m_id[m]] = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (pulso_in[i]) begin
            if (m_pend[m][i] && !(hs && m_id[m] == i))
              m_desc[m] = (m_desc[m] < 255) ? m_desc[m] + 1 : 255;
            np[i] = 1'b1;
          end
        end
        if (m_offer[m]) begin
          if (hs) begin
            m_last[m] = m_id[m]; m_offer[m] = 1'b0; m_cool[m] = cdv[m];
          end
        end else if (m_cool[m] > 0) begin
          m_cool[m] = m_cool[m] - 1;
        end else if (m_pend[m] != 3'b000) begin
          for (int k = 1; k <= 3; k++) begin
            int j;
            j = (m_last[m] + k) % 3;
            if (m_pend[m][j]) begin
              m_id[m] = j; m_offer[m] = 1'b1;
              break;
            end
          end
        end
        m_pend[m] = np;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pulso_in = 3'b000; acao_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b/%b expected 0/0", valid_a, valid_b); end
    checks++; if (id_a !== 2'd0 || id_b !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d/%0d expected 0/0", id_a, id_b); end
    checks++; if (ocup_a !== 1'b0 || ocup_b !== 1'b0) begin failures++; $display("FAIL reset_ocupado: got %b/%b expected 0/0", ocup_a, ocup_b); end
    checks++; if (pend_a !== 3'b000 || desc_a !== 8'd0) begin failures++; $display("FAIL reset_regs: got pend=%b desc=%0d expected 000/0", pend_a, desc_a); end
    $display("tx reset: valid=%b ocupado=%b pend=%b desc=%0d", valid_a, ocup_a, pend_a, desc_a);
  endtask

  task automatic test_single_grant();
    do_reset();
    acao_ready = 1'b1;
    repeat (3) tick();
    pulso_in = 3'b010; tick(); pulso_in = 3'b000;
    checks++; if (pend_a !== 3'b010 || valid_a !== 1'b0) begin failures++; $display("FAIL single_latch: got pend=%b valid=%b expected 010/0", pend_a, valid_a); end
    tick();
    checks++; if (valid_a !== 1'b1 || id_a !== 2'd1) begin failures++; $display("FAIL single_offer: got valid=%b id=%0d expected 1/1", valid_a, id_a); end
    tick();
    checks++; if (valid_a !== 1'b0 || ocup_a !== 1'b1 || pend_a !== 3'b000) begin failures++; $display("FAIL single_hs: got valid=%b ocup=%b pend=%b expected 0/1/000", valid_a, ocup_a, pend_a); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (ocup_a !== 1'b1) begin failures++; $display("FAIL single_cooldown: cycle %0d got ocupado=%b expected 1", c, ocup_a); end
    end
    tick();
    checks++; if (ocup_a !== 1'b0 || valid_a !== 1'b0) begin failures++; $display("FAIL single_idle: got ocup=%b valid=%b expected 0/0", ocup_a, valid_a); end
    $display("tx single_grant: id=1 cooldown done ocupado=%b pend=%b", ocup_a, pend_a);
  endtask

  task automatic test_back_to_back();
    do_reset();
    acao_ready = 1'b1;
    pulso_in = 3'b111; tick(); pulso_in = 3'b000;
    checks++; if (pend_b !== 3'b111) begin failures++; $display("FAIL b2b_latch: got %b expected 111", pend_b); end
    for (int g = 0; g < 3; g++) begin
      tick();
      checks++; if (valid_b !== 1'b1 || id_b !== 2'(g)) begin failures++; $display("FAIL b2b_offer: got valid=%b id=%0d expected 1/%0d", valid_b, id_b, g); end
      tick();
      checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL b2b_gap: got valid=%b expected 0", valid_b); end
      $display("tx back_to_back: grant id=%0d", g);
    end
    checks++; if (pend_b !== 3'b000 || desc_b !== 8'd0) begin failures++; $display("FAIL b2b_end: got pend=%b desc=%0d expected 000/0", pend_b, desc_b); end
  endtask

  task automatic test_hold_offer();
    do_reset();
    acao_ready = 1'b0;
    pulso_in = 3'b001; tick(); pulso_in = 3'b000; tick();
    checks++; if (valid_a !== 1'b1 || id_a !== 2'd0) begin failures++; $display("FAIL hold_offer: got valid=%b id=%0d expected 1/0", valid_a, id_a); end
    repeat (3) begin pulso_in = 3'b001; tick(); pulso_in = 3'b000; tick(); end
    pulso_in = 3'b100; tick(); pulso_in = 3'b000;
    checks++; if (id_a !== 2'd0 || valid_a !== 1'b1) begin failures++; $display("FAIL hold_id: got valid=%b id=%0d expected 1/0", valid_a, id_a); end
    checks++; if (desc_a !== 8'd3 || pend_a !== 3'b101) begin failures++; $display("FAIL hold_drops: got desc=%0d pend=%b expected 3/101", desc_a, pend_a); end
    acao_ready = 1'b1; tick();
    checks++; if (pend_a !== 3'b100 || valid_a !== 1'b0) begin failures++; $display("FAIL hold_accept: got pend=%b valid=%b expected 100/0", pend_a, valid_a); end
    repeat (5) tick();
    checks++; if (valid_a !== 1'b1 || id_a !== 2'd2) begin failures++; $display("FAIL hold_next: got valid=%b id=%0d expected 1/2", valid_a, id_a); end
    $display("tx hold_offer: drops=%0d next id=%0d", desc_a, id_a);
  endtask

  task automatic test_same_edge();
    do_reset();
    acao_ready = 1'b0;
    pulso_in = 3'b001; tick(); pulso_in = 3'b000; tick();
    acao_ready = 1'b1; pulso_in = 3'b001; tick(); pulso_in = 3'b000; acao_ready = 1'b0;
    checks++; if (pend_a !== 3'b001 || desc_a !== 8'd0 || valid_a !== 1'b0) begin failures++; $display("FAIL same_edge: got pend=%b desc=%0d valid=%b expected 001/0/0", pend_a, desc_a, valid_a); end
    repeat (5) tick();
    checks++; if (valid_a !== 1'b1 || id_a !== 2'd0) begin failures++; $display("FAIL same_edge_reoffer: got valid=%b id=%0d expected 1/0", valid_a, id_a); end
    $display("tx same_edge: pend=%b desc=%0d", pend_a, desc_a);
  endtask

  task automatic test_saturation();
    do_reset();
    acao_ready = 1'b0;
    pulso_in = 3'b010;
    for (int n = 0; n <= 300; n++) begin
      tick();
      if (n == 100) begin
        checks++; if (desc_a !== 8'd100) begin failures++; $display("FAIL sat_mid: got %0d expected 100", desc_a); end
      end
    end
    pulso_in = 3'b000;
    checks++; if (desc_a !== 8'd255 || desc_b !== 8'd255) begin failures++; $display("FAIL sat_end: got %0d/%0d expected 255/255", desc_a, desc_b); end
    checks++; if (pend_a !== 3'b010) begin failures++; $display("FAIL sat_pend: got %b expected 010", pend_a); end
    $display("tx saturation: descartes=%0d", desc_a);
  endtask

  task automatic test_reset_midcool();
    do_reset();
    acao_ready = 1'b1;
    pulso_in = 3'b111; tick(); pulso_in = 3'b000;
    tick(); tick(); tick();
    checks++; if (pend_a !== 3'b110 || ocup_a !== 1'b1 || valid_a !== 1'b0) begin failures++; $display("FAIL midcool_pre: got pend=%b ocup=%b valid=%b expected 110/1/0", pend_a, ocup_a, valid_a); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (pend_a !== 3'b000 || ocup_a !== 1'b0 || valid_a !== 1'b0 || desc_a !== 8'd0 || id_a !== 2'd0) begin failures++; $display("FAIL midcool_rst: got pend=%b ocup=%b valid=%b desc=%0d id=%0d expected zeros", pend_a, ocup_a, valid_a, desc_a, id_a); end
    pulso_in = 3'b100; tick(); pulso_in = 3'b000; tick();
    checks++; if (valid_a !== 1'b1 || id_a !== 2'd2) begin failures++; $display("FAIL midcool_after: got valid=%b id=%0d expected 1/2", valid_a, id_a); end
    $display("tx reset_midcool: post-reset id=%0d", id_a);
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      pulso_in   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      acao_ready = ($urandom_range(0, 2) != 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick();
      errs = failures;
      checks++; if (pend_a !== m_pend[0] || pend_b !== m_pend[1]) begin failures++; $display("FAIL rnd_pend: cyc %0d got %b/%b expected %b/%b", c, pend_a, pend_b, m_pend[0], m_pend[1]); end
      checks++; if (desc_a !== 8'(m_desc[0]) || desc_b !== 8'(m_desc[1])) begin failures++; $display("FAIL rnd_desc: cyc %0d got %0d/%0d expected %0d/%0d", c, desc_a, desc_b, m_desc[0], m_desc[1]); end
      checks++; if (valid_a !== m_offer[0] || valid_b !== m_offer[1]) begin failures++; $display("FAIL rnd_valid: cyc %0d got %b/%b expected %b/%b", c, valid_a, valid_b, m_offer[0], m_offer[1]); end
      checks++; if (ocup_a !== (m_offer[0] || m_cool[0] > 0) || ocup_b !== (m_offer[1] || m_cool[1] > 0)) begin failures++; $display("FAIL rnd_ocupado: cyc %0d got %b/%b", c, ocup_a, ocup_b); end
      if (m_offer[0]) begin
        checks++; if (id_a !== 2'(m_id[0])) begin failures++; $display("FAIL rnd_id_a: cyc %0d got %0d expected %0d", c, id_a, m_id[0]); end
      end
      if (m_offer[1]) begin
        checks++; if (id_b !== 2'(m_id[1])) begin failures++; $display("FAIL rnd_id_b: cyc %0d got %0d expected %0d", c, id_b, m_id[1]); end
      end
      if (failures != errs && failures > 40) begin
        $display("FAIL rnd_abort: too many mismatches at cycle %0d", c);
        break;
      end
    end
    rst_n = 1'b1; pulso_in = 3'b000;
    $display("tx random: 3000 cycles, failures so far=%0d", failures);
  endtask

  initial begin
    rst_n = 1'b0; pulso_in = 3'b000; acao_ready = 1'b0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_hold_offer();
    test_same_edge();
    test_saturation();
    test_reset_midcool();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbitro_botoes.md
Name: arbitro_botoes

Overview:
- Sits between the per-button debounce blocks and the game state machine.
- Takes N single-cycle debounced button pulses, latches each as a pending request and grants them one at a time, round-robin, over a valid/ready handshake.
- After each accepted action it enforces a cooldown window before the next grant.
- Counts requests lost because that button's request was already pending.

Parameters:
- N_BOTOES, 3, number of button request inputs (2..8)
- ID_W, 2, width of acao_id; must satisfy 2**ID_W >= N_BOTOES
- COOLDOWN, 16, cycles in COOLDOWN state after each handshake (0..65535; 0 = no cooldown)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- pulso_in  in  N_BOTOES  one-cycle debounced press pulses; bit i = button i
- acao_valid  out  1  grant offer to game FSM
- acao_id  out  ID_W  index of granted button; meaningful only while acao_valid=1
- acao_ready  in  1  game FSM accepts offer
- ocupado  out  1  high when state != IDLE
- pendentes  out  N_BOTOES  current pending-request register
- descartes  out  8  saturating count of dropped pulses

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pendentes=0, descartes=0, state=IDLE.
  - acao_valid=0, acao_id=0, ocupado=0, cooldown counter=0.
  - Last-grant pointer = N_BOTOES-1, so index 0 has first priority.
  - Reset mid-offer or mid-cooldown discards everything with no handshake.
- Pending latch, per bit i, each edge:
  - Set if pulso_in[i]=1.
  - Cleared only by a handshake on i.
  - pulso_in[i]=1 on the same edge as the handshake on i: set wins; the bit stays 1 and no drop is counted.
  - pulso_in[i]=1 while pendentes[i]=1 and no handshake on i: drop; descartes += 1.
  - descartes saturates at 255.
  - Several drops on one edge add the popcount of dropped bits, still saturating.
- Round-robin pick:
  - Search pendentes starting at (ptr+1) mod N_BOTOES, ascending with wrap.
  - The first set bit wins.
- States (registered):
  - IDLE: if pendentes != 0, compute the pick, register acao_id=pick, go to OFFER. Otherwise stay.
  - OFFER: acao_valid=1; acao_id held constant until handshake. acao_valid and acao_id are driven from registers, not combinationally from pulso_in.
  - OFFER, handshake edge (acao_valid & acao_ready):
    - Clear pendentes[acao_id].
    - ptr=acao_id.
    - If COOLDOWN>0: load counter=COOLDOWN-1, go to COOLDOWN. Else go to IDLE.
  - OFFER without acao_ready: stay indefinitely. New pulses still latch but do not change acao_id.
  - COOLDOWN: acao_valid=0. If counter=0, go to IDLE; else counter -= 1. The state lasts exactly COOLDOWN cycles.
- Latency:
  - A pulse sampled at edge k sets pendentes at edge k.
  - With state IDLE, acao_valid rises after edge k+1.
  - With COOLDOWN=0 and acao_ready held high, back-to-back grants are spaced 2 cycles apart (OFFER, IDLE, OFFER...).
- Simultaneous pulses on several bits all latch on the same edge and are served in round-robin order from ptr.
- ocupado = (state != IDLE), registered with the state.

Test Plan:
1. Reset, N=3, COOLDOWN=4, ready=1, pulse bit1 at edge 10 → pendentes=3'b010 after edge 10; acao_valid=1 and acao_id=1 after edge 11; handshake at edge 12; ocupado=1 for 4 cycles of COOLDOWN; back in IDLE after edge 16; pendentes=0.
2. Pulse 3'b111 on one edge, ready=1, COOLDOWN=0 → grant order 0,1,2 at 2-cycle spacing; descartes=0; pendentes empties.
3. Hold ready=0 in OFFER on id 0, pulse bit0 three times and bit2 once → acao_id stays 0; descartes=3; pendentes=3'b101. Raise ready → id0 accepted, then id2.
4. Pulse bit0 on the exact handshake edge of id0 → pendentes[0] remains 1; descartes unchanged; id0 re-offered after the cooldown.
5. 300 repeated pulses on a pending bit with ready=0 → descartes saturates at 255, no wrap.
6. Assert rst_n=0 for one edge mid-COOLDOWN with pendentes=3'b110 → all outputs 0, pointer reset; the next pulse on bit2 alone is granted as id2.
